jesd204b_tx_link: RTL
=====================

Name: jesd204b_tx_link

Overview:
- JESD204B transmit link layer for one lane: the transmit-side counterpart of the receive elastic buffer.
- Generates code-group synchronisation (/K/), the initial lane alignment sequence (ILAS) aligned to the local multiframe clock (LMFC), then user data with frame/multiframe character replacement.
- Sits between the DAC sample packer and the 8b/10b PHY; 4 octets per clk, no scrambling.

Parameters:
- F, 2, octets per frame (must divide 4 or be a multiple of 4).
- K, 32, frames per multiframe; MF_CLKS = K*F/4 clocks per multiframe (default 16).
- ILAS_MF, 4, ILAS length in multiframes.
- CFG, 112'h0, 14 link configuration octets sent in ILAS multiframe 1; octet 0 is CFG[7:0].
- RESYNC_CLKS, 4, consecutive sync_n-low clocks that force re-entry to CGS.

Ports:
- clk  in  1  link clock (lane rate/40).
- reset_b  in  1  asynchronous active-low reset.
- sysref  in  1  SYSREF, already in clk domain; its rising edge realigns the LMFC.
- sync_n  in  1  SYNC~ from receiver, asynchronous; double-flop synchronised internally.
- data_in  in  32  user octets; [7:0] is the first octet in time.
- data_req  out  1  data_in is consumed on this edge.
- data_out  out  32  octets to PHY; [7:0] first in time.
- charisk  out  4  per-octet K-character flag.
- link_up  out  1  high in DATA state.
- sync_err  out  1  one-clock pulse on a sync_n low pulse shorter than RESYNC_CLKS in DATA.

Behaviour:
- Reset values: state CGS, lmfc_cnt 0, data_out 32'hBCBCBCBC, charisk 4'hF, data_req 0, link_up 0, sync_err 0.
- LMFC:
  - lmfc_cnt counts 0..MF_CLKS-1 and wraps.
  - sysref_reg is a registered sysref; edge = sysref & ~sysref_reg.
  - On edge, lmfc_cnt <= 0; otherwise it increments.
  - Boundary = (lmfc_cnt == MF_CLKS-1), so a multiframe starts on the next beat.
- sync_n passes through a two-flop synchroniser (sync_s). This adds 2 clocks of latency to all sync_n reactions.
- State CGS:
  - data_out 32'hBCBCBCBC, charisk 4'hF.
  - Leave to ILAS at the first boundary with sync_s=1; ILAS beat 0 then coincides with lmfc_cnt 0.
- State ILAS, ILAS_MF*MF_CLKS beats (ilas_cnt):
  - Each multiframe: octet 0 = /R/ 8'h1C (K); last octet = /A/ 8'h7C (K).
  - Every other octet = its octet index within the multiframe, mod 256 (D).
  - Multiframe 1 only: octet 1 = /Q/ 8'h9C (K); octets 2..15 = CFG (D).
  - Go to DATA after the last beat.
  - If sync_s=0 for RESYNC_CLKS consecutive clocks, go to CGS.
- State DATA:
  - data_req = 1 when state_next is DATA, decoded from registered state, so it is high during the last ILAS beat.
  - data_in sampled on an edge with data_req=1 appears on data_out after that edge: 1 clock latency.
  - Character replacement, applied to the last octet of each frame, comparing against the last octet of the previous frame:
    - last frame of a multiframe (octet 3 at lmfc_cnt MF_CLKS-1): if equal, send /A/ 8'h7C, charisk=1.
    - any other frame end: if equal, send /F/ 8'hFC, charisk=1.
  - The comparison always uses the original (unreplaced) octets. Previous-frame octet history is held across beats.
  - sync_s=0 for RESYNC_CLKS consecutive clocks: go to CGS on the next edge, drop data_req, output /K/ from the next beat.
  - A shorter low pulse: pulse sync_err on the clock sync_s returns high; remain in DATA.
- Simultaneous events:
  - sysref edge during ILAS or DATA: LMFC realigns; ilas_cnt and the state are unaffected. Multiframe octet-index and /A/ positions follow lmfc_cnt.
  - Resync and boundary in the same clock: resync wins.
- Reset mid-operation: all outputs return to reset values asynchronously; the next ILAS needs a new sync_n release.

Decomposition:
- Package jesd204b_pkg holds:
  - K-character constants: K28_5=8'hBC, K28_0=8'h1C, K28_3=8'h7C, K28_4=8'h9C, K28_7=8'hFC.
  - State encoding: CGS, ILAS, DATA.
- Sub-module jesd204b_lmfc: sysref edge detection and the LMFC counter. It outputs lmfc_cnt and boundary and is reusable by the RX elastic buffer.

Test Plan:
- sysref pulse at clk 10, sync_n low → continuous 32'hBCBCBCBC / charisk F; lmfc_cnt == 0 on clk 11.
- sync_n released mid-multiframe → ILAS beat 0 starts at the next lmfc_cnt 0. Beat 0 = {8'h03,8'h02,8'h01,8'h1C}, charisk 4'b0001. Beat 15 ends with 8'h7C.
- ILAS multiframe 1 with CFG=112'h0D0C...0100 → /Q/ at octet 1, CFG octets 2..15 in order; DATA starts after 64 beats.
- data_in = 32'h44332211 on the first data_req edge → data_out 32'h44332211 one clock later, charisk 0.
- data_in constant 32'h55555555 → charisk 4'b1010 with /F/ in [31:24] and [15:8]. At lmfc_cnt 15, [31:24] = 8'h7C instead.
- sync_n low 2 clocks in DATA → sync_err pulse, link_up stays 1. Low 4 clocks → CGS, /K/ output, data_req 0; release → new ILAS at the next boundary.

Source files
------------

// File: rtl/jesd204b_pkg.sv
// Shared constants and state encoding for the JESD204B link layer.
package jesd204b_pkg;

  // Control characters used on the lane.
  localparam logic [7:0] K28_5 = 8'hBC; // /K/ code-group sync
  localparam logic [7:0] K28_0 = 8'h1C; // /R/ ILAS multiframe start
  localparam logic [7:0] K28_3 = 8'h7C; // /A/ multiframe end
  localparam logic [7:0] K28_4 = 8'h9C; // /Q/ config data follows
  localparam logic [7:0] K28_7 = 8'hFC; // /F/ frame end

  typedef enum logic [1:0] {
    CGS,
    ILAS,
    DATA
  } link_state_t;

endpackage

// File: rtl/jesd204b_lmfc.sv
// Local multiframe clock: SYSREF edge detection and beat position counter.
module jesd204b_lmfc #(
  parameter int unsigned MF_CLKS = 16,
  parameter int unsigned CW      = (MF_CLKS > 1) ? $clog2(MF_CLKS) : 1
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          sysref,
  output logic [CW-1:0] lmfc_cnt,
  output logic          boundary,
  output logic          mf_start
);

  logic sysref_reg;
  logic sysref_edge;

  assign sysref_edge = sysref & ~sysref_reg;
  assign boundary    = (lmfc_cnt == CW'(MF_CLKS - 1));
  // The next beat is position 0 of a multiframe.
  assign mf_start    = sysref_edge | boundary;

  // SYSREF history and multiframe position counter.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      sysref_reg <= 1'b0;
      lmfc_cnt   <= '0;
    end else begin
      sysref_reg <= sysref;
      lmfc_cnt   <= mf_start ? '0 : lmfc_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/jesd204b_tx_link.sv
// JESD204B single-lane transmit link layer: CGS, ILAS, then user data with
// frame/multiframe character replacement. Four octets per clock.
module jesd204b_tx_link #(
  parameter int unsigned  F           = 2,
  parameter int unsigned  K           = 32,
  parameter int unsigned  ILAS_MF     = 4,
  parameter logic [111:0] CFG         = 112'h0,
  parameter int unsigned  RESYNC_CLKS = 4
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        sysref,
  input  logic        sync_n,
  input  logic [31:0] data_in,
  output logic        data_req,
  output logic [31:0] data_out,
  output logic [3:0]  charisk,
  output logic        link_up,
  output logic        sync_err
);

  import jesd204b_pkg::*;

  localparam int unsigned MF_CLKS    = K * F / 4;
  localparam int unsigned MF_OCTETS  = 4 * MF_CLKS;
  localparam int unsigned CW         = (MF_CLKS > 1) ? $clog2(MF_CLKS) : 1;
  localparam int unsigned ILAS_BEATS = ILAS_MF * MF_CLKS;
  localparam int unsigned IW         = (ILAS_BEATS > 1) ? $clog2(ILAS_BEATS) : 1;
  localparam int unsigned LW         = (RESYNC_CLKS > 1) ? $clog2(RESYNC_CLKS) : 1;

  logic [CW-1:0] lmfc_cnt;
  logic [CW-1:0] pos_nxt;
  logic          boundary;
  logic          mf_start;
  logic          sync_s1;
  logic          sync_s;
  logic [LW-1:0] low_cnt;
  logic          resync;
  link_state_t   state;
  link_state_t   state_next;
  logic [IW-1:0] ilas_cnt;
  logic [IW-1:0] ilas_nxt;
  logic [31:0]   beat_d;
  logic [3:0]    beat_k;
  logic [7:0]    prev_oct;
  logic [7:0]    prev_nxt;
  logic [7:0]    oct;
  logic          prev_vld;
  logic          pvld_nxt;
  int unsigned   idx;
  int unsigned   mf;

  jesd204b_lmfc #(
    .MF_CLKS(MF_CLKS),
    .CW     (CW)
  ) u_lmfc (
    .clk     (clk),
    .reset_b (reset_b),
    .sysref  (sysref),
    .lmfc_cnt(lmfc_cnt),
    .boundary(boundary),
    .mf_start(mf_start)
  );

  // Outputs are registered, so each beat is built from the position it will
  // occupy on the lane: the next LMFC value rather than the current one.
  assign pos_nxt  = mf_start ? '0 : lmfc_cnt + CW'(1);
  assign resync   = ~sync_s & (low_cnt == LW'(RESYNC_CLKS - 1));
  assign data_req = (state_next == DATA);

  // SYNC~ synchroniser and consecutive-low counter.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      sync_s1 <= 1'b0;
      sync_s  <= 1'b0;
      low_cnt <= '0;
    end else begin
      sync_s1 <= sync_n;
      sync_s  <= sync_s1;
      if (sync_s)
        low_cnt <= '0;
      else if (low_cnt != LW'(RESYNC_CLKS - 1))
        low_cnt <= low_cnt + LW'(1);
    end
  end

  // Link state sequencing.
  always_comb begin
    state_next = state;
    ilas_nxt   = ilas_cnt;
    case (state)
      CGS: begin
        if (boundary && sync_s) begin
          state_next = ILAS;
          ilas_nxt   = '0;
        end
      end
      ILAS: begin
        if (resync) begin
          state_next = CGS;
        end else begin
          ilas_nxt = ilas_cnt + IW'(1);
          if (ilas_cnt == IW'(ILAS_BEATS - 1))
            state_next = DATA;
        end
      end
      DATA: begin
        if (resync)
          state_next = CGS;
      end
      default: state_next = CGS;
    endcase
  end

  // Lane beat assembly for the state entered on the next edge.
  // Replacement compares original octets; the first frame after entering
  // DATA has no predecessor, so prev_vld is cleared outside DATA.
  always_comb begin
    beat_d   = {4{K28_5}};
    beat_k   = '1;
    prev_nxt = prev_oct;
    pvld_nxt = 1'b0;
    idx      = 0;
    oct      = '0;
    mf       = 32'(ilas_nxt) / MF_CLKS;
    case (state_next)
      ILAS: begin
        for (int unsigned j = 0; j < 4; j++) begin
          idx       = 32'(pos_nxt) * 4 + j;
          beat_k[j] = 1'b0;
          if (idx == 0) begin
            beat_d[8*j +: 8] = K28_0;
            beat_k[j]        = 1'b1;
          end else if (idx == MF_OCTETS - 1) begin
            beat_d[8*j +: 8] = K28_3;
            beat_k[j]        = 1'b1;
          end else if (mf == 1 && idx == 1) begin
            beat_d[8*j +: 8] = K28_4;
            beat_k[j]        = 1'b1;
          end else if (mf == 1 && idx <= 15) begin
            beat_d[8*j +: 8] = 8'(CFG >> (8 * (idx - 2)));
          end else begin
            beat_d[8*j +: 8] = 8'(idx);
          end
        end
      end
      DATA: begin
        pvld_nxt = prev_vld;
        for (int unsigned j = 0; j < 4; j++) begin
          oct              = data_in[8*j +: 8];
          idx              = 32'(pos_nxt) * 4 + j;
          beat_d[8*j +: 8] = oct;
          beat_k[j]        = 1'b0;
          if (idx % F == F - 1) begin
            if (pvld_nxt && oct == prev_nxt) begin
              beat_d[8*j +: 8] = (idx == MF_OCTETS - 1) ? K28_3 : K28_7;
              beat_k[j]        = 1'b1;
            end
            prev_nxt = oct;
            pvld_nxt = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // State, counters and registered lane outputs.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state    <= CGS;
      ilas_cnt <= '0;
      data_out <= {4{K28_5}};
      charisk  <= '1;
      link_up  <= 1'b0;
      sync_err <= 1'b0;
      prev_oct <= '0;
      prev_vld <= 1'b0;
    end else begin
      state    <= state_next;
      ilas_cnt <= ilas_nxt;
      data_out <= beat_d;
      charisk  <= beat_k;
      link_up  <= (state_next == DATA);
      sync_err <= (state == DATA) && sync_s && (low_cnt != '0);
      prev_oct <= prev_nxt;
      prev_vld <= pvld_nxt;
    end
  end

endmodule
